// File: rtl/vector_player.sv
// Table-driven stimulus player: replays stored vectors, checks the masked
// response one cycle later, and counts failing compares and completed passes.
module vector_player #(
  parameter int VW = 15,
  parameter int RW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [VW-1:0] load_stim,
  input  logic [RW-1:0] load_exp,
  input  logic [RW-1:0] load_mask,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] last_idx,
  input  logic          stop,
  input  logic [RW-1:0] resp_in,
  output logic [VW-1:0] stim_out,
  output logic          stim_valid,
  output logic          busy,
  output logic          done,
  output logic          mismatch,
  output logic [AW-1:0] mismatch_idx,
  output logic [15:0]   err_count,
  output logic [15:0]   pass_count
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [VW-1:0] stim_mem [DEPTH];
  logic [RW-1:0] exp_mem  [DEPTH];
  logic [RW-1:0] mask_mem [DEPTH];
  logic [AW-1:0] idx;
  logic [AW-1:0] last_r;
  logic          mode_r;
  logic          complete;
  logic [AW-1:0] cmp_idx_p1;
  logic          accept, at_last, wrap, to_drain, fail_p1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    wrap      = 1'b0;
    to_drain  = 1'b0;
    at_last   = (idx == last_r);
    case (state)
      IDLE: begin
        if (start && !load_en) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop || (at_last && !mode_r)) begin
          to_drain  = 1'b1;
          state_nxt = DRAIN;
        end else if (at_last) begin
          wrap = 1'b1;
        end
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // stim_valid marks that last cycle's stim_out is what resp_in answers
    fail_p1 = stim_valid &&
              (((resp_in ^ exp_mem[cmp_idx_p1]) & mask_mem[cmp_idx_p1]) != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Table is deliberately outside reset so it survives an aborted run
  always_ff @(posedge clk) begin
    if (load_en && state == IDLE) begin
      stim_mem[load_addr] <= load_stim;
      exp_mem[load_addr]  <= load_exp;
      mask_mem[load_addr] <= load_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stim_out     <= '0;
      stim_valid   <= 1'b0;
      done         <= 1'b0;
      mismatch     <= 1'b0;
      mismatch_idx <= '0;
      err_count    <= '0;
      pass_count   <= '0;
      idx          <= '0;
      last_r       <= '0;
      mode_r       <= 1'b0;
      complete     <= 1'b0;
      cmp_idx_p1   <= '0;
    end else begin
      done     <= 1'b0;
      mismatch <= fail_p1;
      if (fail_p1) begin
        mismatch_idx <= cmp_idx_p1;
        err_count    <= sat_inc(err_count);
      end
      case (state)
        IDLE: begin
          stim_valid <= 1'b0;
          if (accept) begin
            mode_r       <= mode;
            last_r       <= last_idx;
            err_count    <= '0;
            pass_count   <= '0;
            mismatch_idx <= '0;
            idx          <= '0;
            complete     <= 1'b0;
          end
        end
        // issue stage: present vector idx, remember it for next cycle's compare
        RUN: begin
          stim_out   <= stim_mem[idx];
          stim_valid <= 1'b1;
          cmp_idx_p1 <= idx;
          complete   <= at_last;
          if (wrap) begin
            idx        <= '0;
            pass_count <= sat_inc(pass_count);
          end else if (!to_drain) begin
            idx <= idx + 1'b1;
          end
        end
        DRAIN: begin
          stim_valid <= 1'b0;
          done       <= 1'b1;
          if (complete) pass_count <= sat_inc(pass_count);
        end
        default: stim_valid <= 1'b0;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_vector_player.sv
// Directed bench for vector_player: table of run records plus hand-written
// sequences for start/load collisions, mid-run reset and counter saturation.
module tb_vector_player;
  localparam int VW = 15;
  localparam int RW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst, load_en, start, mode, stop;
  logic [AW-1:0] load_addr, last_idx;
  logic [VW-1:0] load_stim;
  logic [RW-1:0] load_exp, load_mask, resp_in;
  logic [VW-1:0] stim_out;
  logic          stim_valid, busy, done, mismatch;
  logic [AW-1:0] mismatch_idx;
  logic [15:0]   err_count, pass_count;

  vector_player #(.VW(VW), .RW(RW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_stim(load_stim), .load_exp(load_exp), .load_mask(load_mask),
    .start(start), .mode(mode), .last_idx(last_idx), .stop(stop),
    .resp_in(resp_in), .stim_out(stim_out), .stim_valid(stim_valid),
    .busy(busy), .done(done), .mismatch(mismatch), .mismatch_idx(mismatch_idx),
    .err_count(err_count), .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         mode;
    int         last;
    int         stop_at;
    int         bad;
    logic [7:0] mask2;
    int         inject_at;
    int         exp_err;
    int         exp_pass;
    int         exp_midx;
  } run_t;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [VW-1:0] stim_m [4];
  logic [RW-1:0] exp_m  [4];
  logic [RW-1:0] mask_m [4];
  run_t          runs   [7];
  run_t          r_inj;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic load(input int a, input logic [VW-1:0] s, input logic [RW-1:0] e,
                      input logic [RW-1:0] m);
    load_en = 1'b1; load_addr = a[AW-1:0]; load_stim = s; load_exp = e; load_mask = m;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic do_run(input run_t r);
    int   len, nv, e;
    logic fail_prev;
    load(2, stim_m[2], exp_m[2], r.mask2);
    mask_m[2] = r.mask2;
    len = r.last + 1;
    nv  = (r.stop_at >= 0 && (r.mode == 1 || r.stop_at + 2 < len)) ? r.stop_at + 2 : len;
    start = 1'b1; mode = r.mode[0]; last_idx = r.last[AW-1:0];
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("valid_after_start", 32'(stim_valid), 32'd0);
    fail_prev = 1'b0;
    for (int k = 0; k < nv; k++) begin
      @(negedge clk);
      e = k % len;
      chk("stim_seq", 32'(stim_out), 32'(stim_m[e]));
      chk("stim_valid_run", 32'(stim_valid), 32'd1);
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      chk("mismatch_run", 32'(mismatch), 32'(fail_prev));
      resp_in   = exp_m[e] ^ ((e == r.bad) ? 8'h01 : 8'h00);
      fail_prev = (e == r.bad) && mask_m[e][0];
      start = 1'b0; load_en = 1'b0; stop = 1'b0;
      if (k == r.stop_at) stop = 1'b1;
      if (k == r.inject_at) begin
        start = 1'b1; mode = ~mode; load_en = 1'b1; load_addr = '0;
        load_stim = 15'h7FFF; load_exp = 8'h00; load_mask = 8'h00;
      end
    end
    @(negedge clk);
    start = 1'b0; load_en = 1'b0; stop = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("valid_end", 32'(stim_valid), 32'd0);
    chk("stim_hold", 32'(stim_out), 32'(stim_m[(nv - 1) % len]));
    chk("mismatch_last", 32'(mismatch), 32'(fail_prev));
    chk("err_count", 32'(err_count), 32'(r.exp_err));
    chk("pass_count", 32'(pass_count), 32'(r.exp_pass));
    chk("mismatch_idx", 32'(mismatch_idx), 32'(r.exp_midx));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("mismatch_idle", 32'(mismatch), 32'd0);
    chk("err_hold", 32'(err_count), 32'(r.exp_err));
  endtask

  initial begin
    logic seen;
    rst = 1'b1; load_en = 1'b0; start = 1'b0; mode = 1'b0; stop = 1'b0;
    load_addr = '0; load_stim = '0; load_exp = '0; load_mask = '0;
    last_idx = '0; resp_in = '0;
    stim_m = '{15'h0207, 15'h0404, 15'h0612, 15'h0819};
    exp_m  = '{8'h11, 8'h22, 8'h33, 8'h44};
    mask_m = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    //              mode last stop bad mask2  inj err pass midx
    runs[0] = '{0, 3, -1, -1, 8'hFF, -1, 0, 1, 0};
    runs[1] = '{0, 3, -1,  2, 8'hFE, -1, 0, 1, 0};
    runs[2] = '{0, 3, -1,  2, 8'hFF, -1, 1, 1, 2};
    runs[3] = '{1, 1,  4, -1, 8'hFF, -1, 0, 3, 0};
    runs[4] = '{0, 0, -1, -1, 8'hFF, -1, 0, 1, 0};
    runs[5] = '{0, 3,  0, -1, 8'hFF, -1, 0, 0, 0};
    runs[6] = '{1, 2,  3,  2, 8'hFF, -1, 1, 1, 2};
    r_inj   = '{0, 3, -1, -1, 8'hFF,  1, 0, 1, 0};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(stim_valid), 32'd0);
    chk("rst_stim", 32'(stim_out), 32'd0);
    chk("rst_counts", 32'({err_count, pass_count}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) load(i, stim_m[i], exp_m[i], mask_m[i]);
    for (int i = 0; i < 7; i++) do_run(runs[i]);

    // start together with load_en: entry 3 written, run not started
    load_en = 1'b1; load_addr = 2'd3; load_stim = 15'h1234; load_exp = 8'h55;
    load_mask = 8'hFF; start = 1'b1; mode = 1'b0; last_idx = 2'd3;
    @(negedge clk);
    load_en = 1'b0; start = 1'b0;
    chk("start_with_load_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("start_with_load_valid", 32'(stim_valid), 32'd0);
    stim_m[3] = 15'h1234; exp_m[3] = 8'h55;
    do_run(r_inj);
    do_run(runs[0]);

    // reset at the third vector of a run with every response wrong
    resp_in = 8'h00; start = 1'b1; mode = 1'b0; last_idx = 2'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_stim", 32'(stim_out), 32'(stim_m[2]));
    chk("pre_rst_err", 32'(err_count), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_stim", 32'(stim_out), 32'd0);
    chk("mid_rst_flags", 32'({stim_valid, busy, done, mismatch}), 32'd0);
    chk("mid_rst_midx", 32'(mismatch_idx), 32'd0);
    chk("mid_rst_counts", 32'({err_count, pass_count}), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'({done, busy}), 32'd0);
    end
    do_run(runs[0]);

    // error counter saturation in loop mode
    resp_in = 8'h00; start = 1'b1; mode = 1'b1; last_idx = 2'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (65545) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("sat_done_seen", 32'(seen), 32'd1);
    chk("err_saturated", 32'(err_count), 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_player.md
VECTOR_PLAYER -- requirements
Module: vector_player

Interface
REQ-001 Parameter VW, default 15: stimulus vector width; the stimulus is the concatenated sw/btn/usb strobe bundle.
REQ-002 Parameter RW, default 8: response width, matching the led bus.
REQ-003 Parameter AW, default 2: address width; table depth is 2**AW entries.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 load_en  input  1  write one table entry this cycle.
REQ-007 load_addr  input  AW  table entry index.
REQ-008 load_stim  input  VW  stimulus value to store.
REQ-009 load_exp  input  RW  expected response to store.
REQ-010 load_mask  input  RW  compare mask to store; 1 = bit checked.
REQ-011 start  input  1  one-cycle run request.
REQ-012 mode  input  1  0 = single pass, 1 = loop until stop; sampled with start.
REQ-013 last_idx  input  AW  final entry index of the pass; sampled with start.
REQ-014 stop  input  1  end a loop run after the current vector.
REQ-015 resp_in  input  RW  response from the device under test.
REQ-016 stim_out  output  VW  registered stimulus vector.
REQ-017 stim_valid  output  1  stim_out carries a table entry.
REQ-018 busy  output  1  run in progress.
REQ-019 done  output  1  one-cycle pulse at run end.
REQ-020 mismatch  output  1  one-cycle pulse when a masked compare fails.
REQ-021 mismatch_idx  output  AW  index of the most recent failing entry.
REQ-022 err_count  output  16  failing-compare count.
REQ-023 pass_count  output  16  completed-pass count.

Function
REQ-024 The block SHALL implement the states IDLE, RUN and DRAIN.
REQ-025 The table is 2**AW entries of {stim, exp, mask}; it SHALL be written only when load_en is high in IDLE, and load_en SHALL be ignored while busy.
REQ-026 start in IDLE with load_en low SHALL latch mode and last_idx, clear err_count, pass_count and mismatch_idx, set idx to 0, and enter RUN.
REQ-027 start while busy, or together with load_en, SHALL be ignored.
REQ-028 Each RUN cycle SHALL register stim_out = stim[idx] and set stim_valid = 1, so vector 0 appears on the edge after start is accepted.
REQ-029 resp_in for vector i SHALL be sampled at the edge following the cycle in which stim_out carried vector i, giving a fixed latency of 1.
REQ-030 The sampled response SHALL be compared as ((resp_in ^ exp[i]) & mask[i]) != 0.
REQ-031 On a failing compare, mismatch SHALL pulse on the following cycle, mismatch_idx SHALL take i, and err_count SHALL increment, saturating at 16'hFFFF.
REQ-032 When idx == last_idx in mode 0, the block SHALL enter DRAIN.
REQ-033 When idx == last_idx in mode 1, idx SHALL wrap to 0 and pass_count SHALL increment, saturating at 16'hFFFF.
REQ-034 stop seen in RUN SHALL let the current vector complete and then enter DRAIN; in mode 0, stop SHALL end the pass early.
REQ-035 In DRAIN, stim_valid SHALL be 0 and stim_out SHALL hold its last value.
REQ-036 In DRAIN, the final vector's response SHALL be compared, pass_count SHALL increment if the pass was complete, and done SHALL pulse one cycle later as the block returns to IDLE.
REQ-037 last_idx = 0 SHALL give a one-vector pass.
REQ-038 busy SHALL be 1 in RUN and DRAIN and 0 in IDLE.
REQ-039 The counters SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-040 rst SHALL override all other inputs.
REQ-041 rst SHALL force IDLE, stim_out = 0, stim_valid = 0, busy = 0, done = 0, mismatch = 0, mismatch_idx = 0, err_count = 0, pass_count = 0.
REQ-042 Table contents SHALL be unaffected by rst.
REQ-043 rst asserted mid-run SHALL abort the run with no done pulse.

Verification
REQ-044 Load entries 0..3 with stim 15'h0207/15'h0404/15'h0612/15'h0819 and exp equal to resp_in, mask 8'hFF; start with mode 0, last_idx 3 -> stim_out sequence 0207, 0404, 0612, 0819 on 4 consecutive cycles, err_count 0, pass_count 1, done pulses once.
REQ-045 Response for entry 2 differs in bit 0 with mask 8'hFE -> no mismatch; with mask 8'hFF -> one mismatch pulse, mismatch_idx 2, err_count 1.
REQ-046 Mode 1, last_idx 1, stop asserted after 5 vectors -> stim pattern 0,1,0,1,0,1; done pulses once; pass_count 3.
REQ-047 start asserted together with load_en, and start asserted during RUN -> both ignored; the table entry is written in the first case only.
REQ-048 rst asserted at the third vector of a run -> all outputs are 0 on the next cycle, no done pulse; a fresh start replays the unchanged table.
REQ-049 Force 65536 failures in mode 1 -> err_count saturates at FFFF.
